wb_arbiter: RTL and testbench

Round-robin arbiter that shares the register file's single write-back port among N_REQ execution units. Each unit offers a (destination register, result) pair with a valid/ready handshake. The arbiter grants at most one per cycle and drives the registered write-back bus (wb, wb_r, result) into the decode stage's register file, which clears that register's reservation.

---
 rtl/wb_arbiter_pkg.sv | 21 ++
 rtl/wb_arbiter_rr_pick.sv | 35 +++
 rtl/wb_arbiter.sv | 84 ++++++++
 tb/tb_wb_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared constants and helpers for the write-back arbiter.
// WORD/W_OPR size the result bus, W_RD sizes the register address,
// DEFAULT_N_REQ is the default requester count, clog2 sizes the pointer.
package wb_arbiter_pkg;

    localparam int WORD          = 32;
    localparam int W_RD          = 4;
    localparam int W_OPR         = WORD;
    localparam int DEFAULT_N_REQ = 4;

    // Smallest r with 2**r >= n; callers guarantee n >= 2 so r >= 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/wb_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first set bit of valid
// found by scanning upward from ptr with wrap, as a one-hot grant plus
// its binary index. Grant is zero when no bit is set.
module wb_arbiter_rr_pick
    import wb_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ,
    parameter int PTR_W = clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] grant,
    output logic [PTR_W-1:0] idx
);

    logic             found;
    logic [PTR_W-1:0] cand;

    // Scan N_REQ candidates starting at ptr; the first valid one wins.
    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!found && valid[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin arbiter for the register file's single write-back port.
// Optional feature macro: WB_ARB_R0_DROP_EN -- when defined, a request to
// register 0 is accepted normally but does not raise wb_o.
//
// Handshake: requester i transfers when req_v_i[i] and req_ready_o[i] are
// both high at a rising clk edge; the requester holds valid, register and
// result stable until then. req_ready_o is combinational, one-hot or zero,
// and zero during reset or while wb_hold_i is high.
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int N_REQ = DEFAULT_N_REQ
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req_v_i,
    input  logic [N_REQ*W_RD-1:0]  req_r_i,
    input  logic [N_REQ*W_OPR-1:0] req_result_i,
    output logic [N_REQ-1:0]       req_ready_o,
    input  logic                   wb_hold_i,
    output logic                   wb_o,
    output logic [W_RD-1:0]        wb_r_o,
    output logic [W_OPR-1:0]       result_o
);

    localparam int PTR_W = clog2(N_REQ);

    logic [PTR_W-1:0] ptr;
    logic [N_REQ-1:0] pick_grant;
    logic [PTR_W-1:0] pick_idx;
    logic             grant_any;
    logic [W_RD-1:0]  sel_r;
    logic [W_OPR-1:0] sel_result;
    logic             sel_wb;

    wb_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .valid (req_v_i),
        .ptr   (ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    // Hold and reset both suppress the grant without disturbing the pick.
    assign req_ready_o = (reset || wb_hold_i) ? '0 : pick_grant;
    assign grant_any   = |req_ready_o;

    assign sel_r      = req_r_i[pick_idx*W_RD +: W_RD];
    assign sel_result = req_result_i[pick_idx*W_OPR +: W_OPR];

`ifdef WB_ARB_R0_DROP_EN
    // Register 0 is hard-wired in the register file; accept but do not strobe.
    assign sel_wb = (sel_r != '0);
`else
    assign sel_wb = 1'b1;
`endif

    // Pointer moves to one past the granted index, wrapping at N_REQ.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr <= '0;
        end else if (grant_any) begin
            ptr <= (pick_idx == PTR_W'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end

    // Write-back register: strobe for one cycle per grant, data holds otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            wb_o     <= 1'b0;
            wb_r_o   <= '0;
            result_o <= '0;
        end else if (grant_any) begin
            wb_o     <= sel_wb;
            wb_r_o   <= sel_r;
            result_o <= sel_result;
        end else begin
            wb_o     <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a table of per-cycle inputs with the
// expected one-hot grant, plus hand-written sequences. Expected write-back
// outputs are queued when a cycle is driven and compared one cycle later.
module tb_wb_arbiter;

    localparam int N_REQ = 4;
    localparam int W_RD  = 4;
    localparam int W_OPR = 32;
    localparam int EXP_W = 1 + W_RD + W_OPR;

    logic                   clk;
    logic                   reset;
    logic [N_REQ-1:0]       req_v_i;
    logic [N_REQ*W_RD-1:0]  req_r_i;
    logic [N_REQ*W_OPR-1:0] req_result_i;
    logic [N_REQ-1:0]       req_ready_o;
    logic                   wb_hold_i;
    logic                   wb_o;
    logic [W_RD-1:0]        wb_r_o;
    logic [W_OPR-1:0]       result_o;

    wb_arbiter #(.N_REQ(N_REQ)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_v_i      (req_v_i),
        .req_r_i      (req_r_i),
        .req_result_i (req_result_i),
        .req_ready_o  (req_ready_o),
        .wb_hold_i    (wb_hold_i),
        .wb_o         (wb_o),
        .wb_r_o       (wb_r_o),
        .result_o     (result_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [EXP_W-1:0] exp_q[$];
    int               n_checks;
    int               n_fail;

    logic [W_RD-1:0]  cur_r   [N_REQ];
    logic [W_OPR-1:0] cur_res [N_REQ];
    logic [W_RD-1:0]  last_r;
    logic [W_OPR-1:0] last_res;

    typedef struct {
        logic             rst;
        logic             hold;
        logic [N_REQ-1:0] v;
        logic [N_REQ-1:0] exp_ready;
    } vec_t;

    localparam int N_VEC = 29;
    vec_t vecs[N_VEC];

    task automatic chk(input string name, input logic [W_OPR-1:0] act, input logic [W_OPR-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- driver: one cycle ----------------
    task automatic step(input logic rst, input logic hold, input logic [N_REQ-1:0] v,
                        input logic [N_REQ-1:0] exp_ready);
        logic [EXP_W-1:0] e;
        logic             exp_wb;
        int               g;
        @(negedge clk);
        // Outputs registered at the edge just past belong to the previous cycle.
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wb_o",     {31'd0, wb_o},   {31'd0, e[EXP_W-1]});
            chk("wb_r_o",   {28'd0, wb_r_o}, {28'd0, e[W_OPR +: W_RD]});
            chk("result_o", result_o,        e[W_OPR-1:0]);
        end
        reset     = rst;
        wb_hold_i = hold;
        req_v_i   = v;
        for (int i = 0; i < N_REQ; i++) begin
            req_r_i[i*W_RD +: W_RD]       = cur_r[i];
            req_result_i[i*W_OPR +: W_OPR] = cur_res[i];
        end
        #1;
        chk("req_ready_o", {28'd0, req_ready_o}, {28'd0, exp_ready});
        // Model of the next-cycle write-back outputs.
        g = -1;
        for (int i = 0; i < N_REQ; i++) begin
            if (exp_ready[i]) g = i;
        end
        exp_wb = 1'b0;
        if (rst) begin
            last_r   = '0;
            last_res = '0;
        end else if (g >= 0) begin
            last_r   = cur_r[g];
            last_res = cur_res[g];
`ifdef WB_ARB_R0_DROP_EN
            exp_wb   = (cur_r[g] != '0);
`else
            exp_wb   = 1'b1;
`endif
        end
        exp_q.push_back({exp_wb, last_r, last_res});
        // An accepted requester presents a fresh transaction next time.
        if (!rst && g >= 0) begin
            cur_r[g]   = W_RD'($urandom_range(0, 15));
            cur_res[g] = $urandom;
        end
    endtask

    // ---------------- test ----------------
    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset     = 1'b1;
        wb_hold_i = 1'b0;
        req_v_i   = '0;
        req_r_i   = '0;
        req_result_i = '0;
        last_r    = '0;
        last_res  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cur_r[i]   = W_RD'($urandom_range(1, 15));
            cur_res[i] = $urandom;
        end

        //           rst   hold  valid    expected ready
        vecs[0]  = '{1'b1, 1'b0, 4'b1111, 4'b0000};
        vecs[1]  = '{1'b1, 1'b0, 4'b1111, 4'b0000};
        vecs[2]  = '{1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[3]  = '{1'b0, 1'b0, 4'b1111, 4'b0001};
        vecs[4]  = '{1'b0, 1'b0, 4'b1111, 4'b0010};
        vecs[5]  = '{1'b0, 1'b0, 4'b1111, 4'b0100};
        vecs[6]  = '{1'b0, 1'b0, 4'b1111, 4'b1000};
        vecs[7]  = '{1'b0, 1'b0, 4'b1111, 4'b0001};
        vecs[8]  = '{1'b0, 1'b0, 4'b1111, 4'b0010};
        vecs[9]  = '{1'b0, 1'b0, 4'b1111, 4'b0100};
        vecs[10] = '{1'b0, 1'b0, 4'b1111, 4'b1000};
        vecs[11] = '{1'b0, 1'b1, 4'b0010, 4'b0000};
        vecs[12] = '{1'b0, 1'b1, 4'b0010, 4'b0000};
        vecs[13] = '{1'b0, 1'b1, 4'b0010, 4'b0000};
        vecs[14] = '{1'b0, 1'b0, 4'b0010, 4'b0010};
        vecs[15] = '{1'b0, 1'b0, 4'b1010, 4'b1000};
        vecs[16] = '{1'b0, 1'b0, 4'b0010, 4'b0010};
        vecs[17] = '{1'b0, 1'b0, 4'b0101, 4'b0100};
        vecs[18] = '{1'b0, 1'b0, 4'b0001, 4'b0001};
        vecs[19] = '{1'b0, 1'b0, 4'b1001, 4'b1000};
        vecs[20] = '{1'b0, 1'b0, 4'b0000, 4'b0000};
        vecs[21] = '{1'b0, 1'b1, 4'b1110, 4'b0000};
        vecs[22] = '{1'b0, 1'b0, 4'b1100, 4'b0100};
        vecs[23] = '{1'b0, 1'b0, 4'b1100, 4'b1000};
        vecs[24] = '{1'b1, 1'b0, 4'b1001, 4'b0000};
        vecs[25] = '{1'b0, 1'b0, 4'b1001, 4'b0001};
        vecs[26] = '{1'b0, 1'b0, 4'b0010, 4'b0010};
        vecs[27] = '{1'b1, 1'b0, 4'b0000, 4'b0000};
        vecs[28] = '{1'b0, 1'b0, 4'b0101, 4'b0001};

        for (int k = 0; k < N_VEC; k++) begin
            step(vecs[k].rst, vecs[k].hold, vecs[k].v, vecs[k].exp_ready);
        end

        // Single request from requester 2 with known data; pointer then sits at 3.
        cur_r[2]   = 4'd5;
        cur_res[2] = 32'hDEADBEEF;
        step(1'b0, 1'b0, 4'b0100, 4'b0100);
        step(1'b0, 1'b0, 4'b1001, 4'b1000);

        // Write to register 0.
        cur_r[0]   = 4'd0;
        cur_res[0] = 32'h0000_1234;
        step(1'b0, 1'b0, 4'b0001, 4'b0001);

        // Idle cycles: strobe drops, data holds; drains the queue.
        step(1'b0, 1'b0, 4'b0000, 4'b0000);
        step(1'b0, 1'b0, 4'b0000, 4'b0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
